// File: rtl/io_pkg.sv
// Shared definitions for the I/O freeze controller family: FSM encoding and width helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FROZEN  = 2'd1,
        HOLDOFF = 2'd2
    } frz_state_t;

    // Width of a channel index; a single channel still needs a 1-bit field.
    function automatic int cause_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse on the debounced level.
// Latency: raw change to press pulse is 2 + DEB_CYCLES cycles.
// Backpressure: none; press is a 1-cycle pulse and is lost if the consumer ignores it.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press
);

    localparam int            CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Flip the stable level only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync_2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of the level for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/freeze_ctrl_multi.sv
// Processor freeze controller: stalls the datapath on any enabled request, released by button or timeout.
// Latency: congela rises 1 cycle after an enabled request in IDLE; falls 1 cycle after the debounced press.
// Backpressure: none; requests are levels, one freeze per request assertion, HOLDOFF waits for all to drop.
module freeze_ctrl_multi
    import io_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int DEB_CYCLES = 50000,
    parameter int TIMEOUT    = 0,
    parameter int CNT_W      = 16,
    localparam int CAUSE_W   = cause_width(N_CH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               botao_raw,
    input  logic [N_CH-1:0]    req,
    input  logic [N_CH-1:0]    req_en,
    output logic               congela,
    output logic               release_pulse,
    output logic [CAUSE_W-1:0] cause,
    output logic               timed_out,
    output logic [CNT_W-1:0]   freeze_count
);

    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    frz_state_t        state;
    logic [TMR_W-1:0]  timer;
    logic [N_CH-1:0]   act;
    logic              any;
    logic              press;

    // Lowest enabled channel index wins when several request together.
    function automatic logic [CAUSE_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
        logic [CAUSE_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CAUSE_W'(i);
        end
        return idx;
    endfunction

    assign act = req & req_en;
    assign any = |act;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (botao_raw),
        .press   (press)
    );

    // Freeze FSM with registered outputs, timeout timer and saturating event counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            congela       <= 1'b0;
            release_pulse <= 1'b0;
            cause         <= '0;
            timed_out     <= 1'b0;
            freeze_count  <= '0;
            timer         <= '0;
        end else begin
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state     <= FROZEN;
                        congela   <= 1'b1;
                        cause     <= lowest_idx(act);
                        timed_out <= 1'b0;
                        timer     <= '0;
                        if (freeze_count != '1) begin
                            freeze_count <= freeze_count + 1'b1;
                        end
                    end
                end
                FROZEN: begin
                    // Button has priority over a timeout expiring in the same cycle.
                    if (press) begin
                        state         <= HOLDOFF;
                        congela       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else if ((TIMEOUT != 0) && (timer == TMR_LAST)) begin
                        state         <= HOLDOFF;
                        congela       <= 1'b0;
                        release_pulse <= 1'b1;
                        timed_out     <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HOLDOFF: begin
                    // Wait for every enabled request to drop so one assertion gives one freeze.
                    if (!any) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    congela <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freeze_ctrl_multi.sv
// Bench for freeze_ctrl_multi: three configurations driven in parallel against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_freeze_ctrl_multi;

    localparam int DEB = 4;
    localparam int NI  = 3;
    localparam int M_IDLE = 0, M_FROZEN = 1, M_HOLD = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       botao_raw;
    logic [2:0] req;
    logic [2:0] req_en;

    logic        c0, c1, c2, r0, r1, r2, t0, t1, t2;
    logic [1:0]  k0, k1, k2;
    logic [15:0] n0, n1;
    logic [1:0]  n2;

    logic        congela_o [NI];
    logic        rp_o      [NI];
    logic        timed_o   [NI];
    logic [1:0]  cause_o   [NI];
    logic [15:0] cnt_o     [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_st [NI];
    int m_cause [NI];
    int m_timed [NI];
    int m_cnt [NI];
    int m_rp [NI];
    int m_fc [NI];
    int to_p [NI] = '{0, 10, 0};
    int cmax [NI] = '{65535, 65535, 3};
    bit hist [$];
    bit m_stable;
    bit m_press;

    always #5 clk = ~clk;

    freeze_ctrl_multi #(.N_CH(3), .DEB_CYCLES(DEB), .TIMEOUT(0), .CNT_W(16)) u_base (
        .clk(clk), .reset_n(reset_n), .botao_raw(botao_raw), .req(req), .req_en(req_en),
        .congela(c0), .release_pulse(r0), .cause(k0), .timed_out(t0), .freeze_count(n0));

    freeze_ctrl_multi #(.N_CH(3), .DEB_CYCLES(DEB), .TIMEOUT(10), .CNT_W(16)) u_to (
        .clk(clk), .reset_n(reset_n), .botao_raw(botao_raw), .req(req), .req_en(req_en),
        .congela(c1), .release_pulse(r1), .cause(k1), .timed_out(t1), .freeze_count(n1));

    freeze_ctrl_multi #(.N_CH(3), .DEB_CYCLES(DEB), .TIMEOUT(0), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .botao_raw(botao_raw), .req(req), .req_en(req_en),
        .congela(c2), .release_pulse(r2), .cause(k2), .timed_out(t2), .freeze_count(n2));

    always_comb begin
        congela_o[0] = c0; congela_o[1] = c1; congela_o[2] = c2;
        rp_o[0]      = r0; rp_o[1]      = r1; rp_o[2]      = r2;
        timed_o[0]   = t0; timed_o[1]   = t1; timed_o[2]   = t2;
        cause_o[0]   = k0; cause_o[1]   = k1; cause_o[2]   = k2;
        cnt_o[0]     = n0; cnt_o[1]     = n1; cnt_o[2]     = {14'd0, n2};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_st[i] = M_IDLE; m_cause[i] = 0; m_timed[i] = 0;
            m_cnt[i] = 0; m_rp[i] = 0; m_fc[i] = 0;
        end
        hist.delete();
        for (int k = 0; k < DEB + 2; k++) hist.push_back(1'b0);
        m_stable = 1'b0;
        m_press  = 1'b0;
    endtask

    // One clock edge of the reference: FSM consumes the press visible before the edge,
    // then the button history decides whether the debounced level flips at this edge.
    task automatic model_edge();
        logic [2:0] act;
        bit all_diff;
        int c;
        int sz;
        if (!reset_n) begin
            model_reset();
            return;
        end
        act = req & req_en;
        for (int i = 0; i < NI; i++) begin
            m_rp[i] = 0;
            if (m_st[i] == M_IDLE) begin
                if (act != 3'b000) begin
                    c = 0;
                    for (int b = 2; b >= 0; b--) if (act[b]) c = b;
                    m_st[i] = M_FROZEN; m_cause[i] = c; m_timed[i] = 0; m_fc[i] = 0;
                    if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                end
            end else if (m_st[i] == M_FROZEN) begin
                m_fc[i]++;
                if (m_press) begin
                    m_st[i] = M_HOLD; m_rp[i] = 1;
                end else if (to_p[i] != 0 && m_fc[i] == to_p[i]) begin
                    m_st[i] = M_HOLD; m_rp[i] = 1; m_timed[i] = 1;
                end
            end else begin
                if (act == 3'b000) m_st[i] = M_IDLE;
            end
        end
        hist.push_back(botao_raw);
        sz = hist.size();
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (hist[sz - 3 - k] == m_stable) all_diff = 1'b0;
        m_press = 1'b0;
        if (all_diff) begin
            m_stable = ~m_stable;
            m_press  = m_stable;
        end
        while (hist.size() > 32) void'(hist.pop_front());
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("congela[%0d]", i), congela_o[i], m_st[i] == M_FROZEN);
            check_eq($sformatf("release_pulse[%0d]", i), rp_o[i], m_rp[i]);
            check_eq($sformatf("cause[%0d]", i), cause_o[i], m_cause[i]);
            check_eq($sformatf("timed_out[%0d]", i), timed_o[i], m_timed[i]);
            check_eq($sformatf("freeze_count[%0d]", i), cnt_o[i], m_cnt[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold the button for a clean press, then let it settle low again.
    task automatic press_btn();
        botao_raw = 1'b1;
        steps(6);
        botao_raw = 1'b0;
        steps(8);
    endtask

    initial begin
        int lat;
        int raw_left;
        reset_n = 1'b0; botao_raw = 1'b0; req = 3'b111; req_en = 3'b111;
        model_reset();
        #1;
        check_eq("reset_congela", c0, 1'b0);
        check_eq("reset_count", n0, 16'd0);
        steps(3);
        reset_n = 1'b1;
        step();
        check_eq("post_reset_freeze", c0, 1'b1);

        // release and return to idle
        req = 3'b000;
        press_btn();
        steps(2);

        // single channel freeze, press latency, no re-freeze while held
        req = 3'b100;
        steps(3);
        botao_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 6) botao_raw = 1'b0;
            if (lat == 0 && !c0) lat = i;
        end
        check_eq("press_latency", lat, 2 + DEB + 1);
        steps(5);
        req = 3'b000; step();
        req = 3'b100; steps(3);

        // glitches shorter than the debounce window
        for (int g = 0; g < 3; g++) begin
            botao_raw = 1'b1; steps(3);
            botao_raw = 1'b0; steps(3);
        end
        check_eq("glitch_hold", c0, 1'b1);
        press_btn();
        req = 3'b000; steps(2);

        // priority with mask, press while idle is not remembered
        req_en = 3'b011; req = 3'b110; steps(3);
        press_btn();
        req = 3'b000; steps(2);
        req_en = 3'b111;
        press_btn();
        req = 3'b001; steps(12);
        check_eq("idle_press_dropped", c0, 1'b1);

        // timeout only on u_to; others released afterwards
        steps(4);
        press_btn();
        req = 3'b000; steps(3);

        // press lands exactly on the timeout expiry cycle of u_to
        req = 3'b010; step();
        steps(3);
        botao_raw = 1'b1; steps(6);
        botao_raw = 1'b0; steps(4);
        check_eq("press_beats_timeout", t1, 1'b0);
        req = 3'b000; steps(8);

        // saturation on the 2-bit counter
        for (int f = 0; f < 5; f++) begin
            req = 3'b001; steps(2);
            press_btn();
            req = 3'b000; steps(2);
        end
        check_eq("count_saturated", n2, 2'd3);

        // async reset mid-freeze with a debounce in progress
        req = 3'b001; steps(2);
        botao_raw = 1'b1; steps(3);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_c0", c0, 1'b0);
        check_eq("async_rst_c1", c1, 1'b0);
        check_eq("async_rst_c2", c2, 1'b0);
        botao_raw = 1'b0;
        step();
        reset_n = 1'b1;
        steps(4);

        // randomized traffic
        raw_left = 3;
        for (int it = 0; it < 1500; it++) begin
            if (raw_left == 0) begin
                botao_raw = ~botao_raw;
                raw_left  = $urandom_range(1, 9);
            end
            raw_left--;
            if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) req_en = 3'($urandom_range(0, 7));
            reset_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
